icache_lite: RTL and testbench
==============================

Name: icache_lite

Overview:
- Blocking, direct-mapped, single-beat-line instruction cache.
- Responds to the fetch unit's icache request interface: rd / flush / invalidate / pc / priv in, accept / valid / error / 64-bit inst / page_fault out.
- Refills 8-byte lines from a simple valid/accept memory read port.
- Sits between the frontend fetch stage and the instruction memory or bus.
- Physical addressing only; no MMU.

Parameters:
- NUM_LINES, 64, number of cache lines (power of 2).
- NUM_LINES_W, 6, log2(NUM_LINES).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_rd_i  in  1  fetch read request
- req_flush_i  in  1  invalidate all lines (single-cycle pulse)
- req_invalidate_i  in  1  invalidate the line indexed by req_pc_i
- req_pc_i  in  32  fetch address
- req_priv_i  in  2  privilege level (ignored; no MMU)
- req_accept_o  out  1  request accepted this cycle
- req_valid_o  out  1  response valid
- req_error_o  out  1  bus error on this response
- req_inst_o  out  64  two instructions (8-byte aligned line)
- req_page_fault_o  out  1  constant 0
- mem_rd_o  out  1  refill read request
- mem_addr_o  out  32  refill address, bits [2:0]=0
- mem_accept_i  in  1  memory accepted the request
- mem_valid_i  in  1  refill data valid
- mem_error_i  in  1  refill bus error
- mem_data_i  in  64  refill data

Behaviour:
- Address split:
  - offset = pc[2:0], ignored; the full line is returned.
  - index = pc[NUM_LINES_W+2:3].
  - tag = pc[31:NUM_LINES_W+3].
- Storage:
  - Valid bits are a flop vector.
  - Tag/data arrays are synchronous-read, written only on refill.
- States:
  - READY: accepts requests and performs lookup.
  - MISS_REQ: mem_rd_o held high with a stable mem_addr_o until mem_accept_i.
  - MISS_WAIT: waits for mem_valid_i.
  - RESP: drives the refill response for one cycle.
- Reset:
  - State returns to READY; all valid bits clear in the same cycle.
  - req_valid_o=0, req_error_o=0, req_inst_o=0, mem_rd_o=0, mem_addr_o=0, flush_pending=0.
  - Reset mid-miss abandons the refill. A mem_valid_i seen in READY is ignored.
- req_accept_o = (state==READY) && !flush_pending && !req_flush_i && !miss_detected. Here miss_detected is the combinational lookup miss for the request accepted the previous cycle.
- Hit path:
  - A request accepted at cycle T is looked up at T+1.
  - On a hit (valid && tag match), req_valid_o=1 at T+1 with line data and req_error_o=0.
  - Back-to-back hits sustain one response per cycle.
- Miss path:
  - At T+1 on a miss: req_valid_o=0, req_accept_o=0. Next cycle the state is MISS_REQ with mem_addr_o={pc[31:3],3'b0}.
  - On mem_accept_i, go to MISS_WAIT.
  - On mem_valid_i, capture data and error. If !mem_error_i, write tag/data and set the valid bit; if error, do not fill.
  - Go to RESP. The next cycle has req_valid_o=1, req_inst_o=mem_data_i, req_error_o=mem_error_i. Then return to READY.
  - mem_accept_i and mem_valid_i may arrive in the same cycle. Accept is taken first; valid is only sampled in MISS_WAIT, so the memory must present valid at least one cycle after accept.
- Flush:
  - req_flush_i high in any state sets flush_pending.
  - When the state is READY and no lookup is in flight, all valid bits clear in one cycle, flush_pending clears, and acceptance resumes the following cycle.
  - A flush during a miss completes the miss, including the fill and the response, and then clears all lines.
- Invalidate:
  - req_invalidate_i is sampled only when req_accept_o=1. It clears valid[index(req_pc_i)] at the next edge.
  - If req_rd_i is asserted with it, the read is also accepted and looks up after the clear, so it misses.
  - req_invalidate_i while req_accept_o=0 is ignored.
- A refill to a line and an invalidate of the same index cannot coincide, because accept is low during a miss.
- req_page_fault_o is always 0. req_priv_i is unused.

Test Plan:
- Reset, then read pc=0x1000 with memory returning 0x00000013_00100093 one cycle after accept. Required: mem_addr_o=0x1000, then req_valid_o=1 with that data and req_error_o=0. A repeat read of 0x1004 hits at T+1 with no mem_rd_o.
- Back-to-back hits on 0x1000, 0x1008 and 0x1010, all pre-filled. Required: three consecutive req_valid_o cycles and req_accept_o held high throughout.
- Conflict on index: 0x1000 then 0x1000+(8<<NUM_LINES_W)=0x1200. Required: the second access misses and refills. A re-read of 0x1000 then misses again.
- Memory error: read 0x2000 with mem_error_i=1. Required: req_valid_o=1 and req_error_o=1. An immediate re-read of 0x2000 misses, because the line was not filled.
- Flush asserted during MISS_WAIT. Required: the miss response is still delivered and accept stays low one extra cycle. A subsequent read of the just-filled line misses.
- Invalidate at pc=0x1000 with req_rd_i=1 on a cached line. Required: the read is accepted and misses. Reset asserted during MISS_REQ: mem_rd_o=0 next cycle and every previously filled line misses.

Source files
------------

// File: rtl/icache_lite.sv
// icache_lite: blocking direct-mapped instruction cache with 8-byte lines.
// Lookups occur one cycle after accept, and misses refill through a valid/accept read port.
module icache_lite #(
    parameter int NUM_LINES   = 64,
    parameter int NUM_LINES_W = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_rd_i,
    input  logic        req_flush_i,
    input  logic        req_invalidate_i,
    input  logic [31:0] req_pc_i,
    input  logic [1:0]  req_priv_i,
    output logic        req_accept_o,
    output logic        req_valid_o,
    output logic        req_error_o,
    output logic [63:0] req_inst_o,
    output logic        req_page_fault_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_accept_i,
    input  logic        mem_valid_i,
    input  logic        mem_error_i,
    input  logic [63:0] mem_data_i
);
    localparam int TAG_W = 29 - NUM_LINES_W;

    typedef enum logic [1:0] {READY, MISS_REQ, MISS_WAIT, RESP} state_t;
    state_t state, state_next;

    logic [NUM_LINES-1:0]   valid;
    logic [TAG_W-1:0]       tag_mem [NUM_LINES];
    logic [63:0]            data_mem [NUM_LINES];
    logic [TAG_W-1:0]       tag_rd;
    logic [63:0]            data_rd;
    logic [31:3]            pc_q;
    logic                   lookup_q;
    logic                   flush_pending;
    logic [31:0]            miss_addr;
    logic [63:0]            resp_data;
    logic                   resp_error;
    logic [NUM_LINES_W-1:0] idx_in;
    logic [NUM_LINES_W-1:0] idx_q;
    logic                   hit;
    logic                   miss_detected;
    logic                   accept;
    logic                   do_flush;
    logic                   fill;
    logic                   unused_ok;

    assign idx_in        = req_pc_i[NUM_LINES_W+2:3];
    assign idx_q         = pc_q[NUM_LINES_W+2:3];
    assign hit           = lookup_q && valid[idx_q] && tag_rd == pc_q[31:NUM_LINES_W+3];
    assign miss_detected = lookup_q && !hit;
    assign accept        = state == READY && !flush_pending && !req_flush_i && !miss_detected;
    assign do_flush      = flush_pending && state == READY && !lookup_q;
    assign fill          = state == MISS_WAIT && mem_valid_i && !mem_error_i;
    assign unused_ok     = ^{req_priv_i, req_pc_i[2:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= READY;
        else state <= state_next;
    end

    always_comb begin
        state_next = state == READY     ? (miss_detected ? MISS_REQ : READY) :
                     state == MISS_REQ  ? (mem_accept_i ? MISS_WAIT : MISS_REQ) :
                     state == MISS_WAIT ? (mem_valid_i ? RESP : MISS_WAIT) : READY;
    end

    always_comb begin
        req_accept_o     = accept;
        req_valid_o      = hit || state == RESP;
        req_error_o      = state == RESP && resp_error;
        req_inst_o       = state == RESP ? resp_data : hit ? data_rd : '0;
        req_page_fault_o = 1'b0;
        mem_rd_o         = state == MISS_REQ;
        mem_addr_o       = miss_addr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lookup_q      <= 1'b0;
            flush_pending <= 1'b0;
            valid         <= '0;
            miss_addr     <= '0;
            resp_data     <= '0;
            resp_error    <= 1'b0;
        end else begin
            lookup_q      <= accept && req_rd_i;
            flush_pending <= req_flush_i || (flush_pending && !do_flush);
            if (accept) pc_q <= req_pc_i[31:3];
            if (miss_detected) miss_addr <= {pc_q, 3'b000};
            if (state == MISS_WAIT && mem_valid_i) begin
                resp_data  <= mem_data_i;
                resp_error <= mem_error_i;
            end
            if (do_flush) valid <= '0;
            else if (fill) valid[idx_q] <= 1'b1;
            else if (accept && req_invalidate_i) valid[idx_in] <= 1'b0;
        end
    end

    // Synchronous-read arrays; pc_q is frozen during a miss so idx_q addresses the fill.
    always_ff @(posedge clk_i) begin
        tag_rd  <= tag_mem[idx_in];
        data_rd <= data_mem[idx_in];
        if (fill) begin
            tag_mem[idx_q]  <= pc_q[31:NUM_LINES_W+3];
            data_mem[idx_q] <= mem_data_i;
        end
    end
endmodule

// File: tb/tb_icache_lite.sv
// tb_icache_lite: directed table, corner sequences and random accesses against a line-address model.
module tb_icache_lite;
    localparam int NL = 64;
    localparam int NW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd_i = 1'b0, req_flush_i = 1'b0, req_invalidate_i = 1'b0;
    logic [31:0] req_pc_i = '0;
    logic [1:0]  req_priv_i = 2'b11;
    logic        req_accept_o, req_valid_o, req_error_o, req_page_fault_o;
    logic [63:0] req_inst_o;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i = 1'b0, mem_valid_i = 1'b0, mem_error_i = 1'b0;
    logic [63:0] mem_data_i = '0;

    always #5 clk = ~clk;

    icache_lite #(.NUM_LINES(NL), .NUM_LINES_W(NW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_rd_i(req_rd_i), .req_flush_i(req_flush_i), .req_invalidate_i(req_invalidate_i),
        .req_pc_i(req_pc_i), .req_priv_i(req_priv_i),
        .req_accept_o(req_accept_o), .req_valid_o(req_valid_o), .req_error_o(req_error_o),
        .req_inst_o(req_inst_o), .req_page_fault_o(req_page_fault_o),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_accept_i(mem_accept_i), .mem_valid_i(mem_valid_i),
        .mem_error_i(mem_error_i), .mem_data_i(mem_data_i)
    );

    int vectors = 0;
    int miscompares = 0;
    bit          ref_valid [NL];
    logic [31:3] ref_line  [NL];
    bit          mem_stall = 1'b0;
    int          vd = -1;

    typedef struct {
        logic [31:0] pc;
        bit          inv;
        bit          hit;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [63:0] mdata(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:3], 3'b000};
        return la == 32'h1000 ? 64'h00000013_00100093 : {la ^ 32'h5a5a0f0f, ~la};
    endfunction

    function automatic bit merr(input logic [31:0] a);
        return a[31:12] == 20'h2;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[NW+2:3]);
    endfunction

    function automatic bit predict(input logic [31:0] pc, input bit inv);
        return !inv && ref_valid[idx(pc)] && ref_line[idx(pc)] == pc[31:3];
    endfunction

    function automatic logic sig(input int s);
        return s == 0 ? req_accept_o : s == 1 ? mem_rd_o : req_valid_o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_sig(input string name, input int s);
        int n;
        n = 0;
        while (!sig(s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout waiting", name);
        end
    endtask

    task automatic clear_model();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    endtask

    task automatic access(input logic [31:0] pc, input bit inv, input bit exp_hit, input string nm);
        bit e;
        e = !exp_hit && merr(pc);
        @(negedge clk);
        req_rd_i = 1'b1;
        req_pc_i = pc;
        req_invalidate_i = inv;
        wait_sig({nm, " accept"}, 0);
        @(negedge clk);
        req_rd_i = 1'b0;
        req_invalidate_i = 1'b0;
        chk({nm, " hit"}, req_valid_o, exp_hit);
        if (exp_hit) begin
            chk({nm, " data"}, req_inst_o, mdata(pc));
            chk({nm, " err"}, req_error_o, 0);
            chk({nm, " no_mem"}, mem_rd_o, 0);
        end else begin
            chk({nm, " acc_low"}, req_accept_o, 0);
            @(negedge clk);
            chk({nm, " mem_rd"}, mem_rd_o, 1);
            chk({nm, " addr"}, mem_addr_o, {pc[31:3], 3'b000});
            wait_sig({nm, " resp"}, 2);
            chk({nm, " fill_data"}, req_inst_o, mdata(pc));
            chk({nm, " fill_err"}, req_error_o, e);
        end
        if (inv) ref_valid[idx(pc)] = 1'b0;
        if (!exp_hit && !e) begin
            ref_valid[idx(pc)] = 1'b1;
            ref_line[idx(pc)]  = pc[31:3];
        end
    endtask

    // Memory responder: accept after 0-2 cycles, data after a further 1-3 cycles.
    initial begin
        logic [31:0] a;
        forever begin
            do @(negedge clk); while (!mem_rd_o || mem_stall || rst);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = mem_addr_o;
            mem_accept_i = 1'b1;
            @(negedge clk);
            mem_accept_i = 1'b0;
            repeat (vd >= 0 ? vd : int'($urandom_range(0, 2))) @(negedge clk);
            mem_valid_i = 1'b1;
            mem_data_i  = mdata(a);
            mem_error_i = merr(a);
            @(negedge clk);
            mem_valid_i = 1'b0;
            mem_error_i = 1'b0;
            mem_data_i  = {$urandom, $urandom};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] pc;
        bit inv;
        tbl[0] = '{32'h1000, 1'b0, 1'b0};
        tbl[1] = '{32'h1004, 1'b0, 1'b1};
        tbl[2] = '{32'h1008, 1'b0, 1'b0};
        tbl[3] = '{32'h1010, 1'b0, 1'b0};
        tbl[4] = '{32'h1200, 1'b0, 1'b0};
        tbl[5] = '{32'h1000, 1'b0, 1'b0};
        tbl[6] = '{32'h2000, 1'b0, 1'b0};
        tbl[7] = '{32'h2000, 1'b0, 1'b0};
        tbl[8] = '{32'h1000, 1'b1, 1'b0};
        tbl[9] = '{32'h1000, 1'b0, 1'b1};
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst accept", req_accept_o, 1);
        chk("rst valid", req_valid_o, 0);
        chk("rst error", req_error_o, 0);
        chk("rst inst", req_inst_o, 0);
        chk("rst mem_rd", mem_rd_o, 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst page_fault", req_page_fault_o, 0);

        for (int i = 0; i < 4; i++) access(tbl[i].pc, tbl[i].inv, tbl[i].hit, $sformatf("vec%0d", i));

        @(negedge clk);
        req_rd_i = 1'b1;
        req_pc_i = 32'h1000;
        chk("b2b acc0", req_accept_o, 1);
        @(negedge clk);
        req_pc_i = 32'h1008;
        chk("b2b v0", req_valid_o, 1);
        chk("b2b d0", req_inst_o, mdata(32'h1000));
        chk("b2b acc1", req_accept_o, 1);
        @(negedge clk);
        req_pc_i = 32'h1010;
        chk("b2b v1", req_valid_o, 1);
        chk("b2b d1", req_inst_o, mdata(32'h1008));
        chk("b2b acc2", req_accept_o, 1);
        @(negedge clk);
        req_rd_i = 1'b0;
        chk("b2b v2", req_valid_o, 1);
        chk("b2b d2", req_inst_o, mdata(32'h1010));

        for (int i = 4; i < 10; i++) access(tbl[i].pc, tbl[i].inv, tbl[i].hit, $sformatf("vec%0d", i));

        // Invalidate offered while a miss is outstanding must be ignored.
        @(negedge clk);
        req_rd_i = 1'b1;
        req_pc_i = 32'h3018;
        @(negedge clk);
        req_rd_i = 1'b0;
        req_invalidate_i = 1'b1;
        req_pc_i = 32'h1008;
        chk("ign_inv acc", req_accept_o, 0);
        @(negedge clk);
        chk("ign_inv acc2", req_accept_o, 0);
        req_invalidate_i = 1'b0;
        wait_sig("ign_inv resp", 2);
        chk("ign_inv data", req_inst_o, mdata(32'h3018));
        ref_valid[idx(32'h3018)] = 1'b1;
        ref_line[idx(32'h3018)]  = 29'(32'h3018 >> 3);
        access(32'h1008, 1'b0, 1'b1, "ign_inv keep");

        // Flush landing in MISS_WAIT.
        vd = 2;
        @(negedge clk);
        req_rd_i = 1'b1;
        req_pc_i = 32'h3020;
        @(negedge clk);
        req_rd_i = 1'b0;
        wait_sig("fl mem_rd", 1);
        n = 0;
        while (mem_rd_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_flush_i = 1'b1;
        @(negedge clk);
        req_flush_i = 1'b0;
        wait_sig("fl resp", 2);
        chk("fl data", req_inst_o, mdata(32'h3020));
        chk("fl err", req_error_o, 0);
        chk("fl acc_resp", req_accept_o, 0);
        @(negedge clk);
        chk("fl acc_extra", req_accept_o, 0);
        chk("fl valid_low", req_valid_o, 0);
        @(negedge clk);
        chk("fl acc_resume", req_accept_o, 1);
        vd = -1;
        clear_model();
        access(32'h3020, 1'b0, 1'b0, "fl reread");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                req_flush_i = 1'b1;
                @(negedge clk);
                req_flush_i = 1'b0;
                chk("rnd flush acc_low", req_accept_o, 0);
                @(negedge clk);
                chk("rnd flush acc_hi", req_accept_o, 1);
                clear_model();
            end else begin
                pc = ($urandom_range(0, 4) == 0 ? 32'h2000 : 32'h4000)
                   | (32'($urandom_range(0, 7)) << 3)
                   | (32'($urandom_range(0, 1)) << 9)
                   | 32'($urandom_range(0, 7));
                inv = $urandom_range(0, 5) == 0;
                access(pc, inv, predict(pc, inv), $sformatf("rnd%0d pc=%h", k, pc));
            end
        end

        // Reset while the refill request is still outstanding.
        access(32'h1010, 1'b0, predict(32'h1010, 1'b0), "pre_rst fill");
        mem_stall = 1'b1;
        @(negedge clk);
        req_rd_i = 1'b1;
        req_pc_i = 32'h5000;
        @(negedge clk);
        req_rd_i = 1'b0;
        wait_sig("rst mid mem_rd", 1);
        chk("rst mid addr", mem_addr_o, 32'h5000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid mem_rd_low", mem_rd_o, 0);
        chk("rst mid valid", req_valid_o, 0);
        chk("rst mid accept", req_accept_o, 1);
        clear_model();
        mem_stall = 1'b0;
        access(32'h1010, 1'b0, 1'b0, "post_rst miss");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
